// File: rtl/aib_sram_arb.sv
// aib_sram_arb: arbitrates the core port and the APB slave onto one single-port config SRAM.
// Define AIB_SRAM_ARB_STARVE_EN to bound APB waiting under continuous core traffic.
module aib_sram_arb #(
   parameter int ADDR_W = 12,
   parameter int MAX_WAIT = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_mem_req,
   input  logic              i_mem_write,
   input  logic [31:0]       i_mem_addr,
   input  logic [31:0]       i_mem_wdata,
   input  logic [31:0]       i_mem_wmask,
   output logic              o_mem_gnt,
   output logic              o_mem_rvalid,
   output logic [31:0]       o_mem_rdata,
   input  logic              i_psel,
   input  logic              i_penable,
   input  logic              i_pwrite,
   input  logic [31:0]       i_paddr,
   input  logic [31:0]       i_pwdata,
   output logic              o_pready,
   output logic [31:0]       o_prdata,
   output logic              o_sram_cen,
   output logic              o_sram_gwen,
   output logic [31:0]       o_sram_wen,
   output logic [ADDR_W-1:0] o_sram_a,
   output logic [31:0]       o_sram_d,
   input  logic [31:0]       i_sram_q
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t state;
   logic apb_req, gnt_apb, force_apb;
   logic unused_addr;
   assign unused_addr = ^{i_mem_addr[31:ADDR_W], i_paddr[31:ADDR_W+2], i_paddr[1:0]};
   assign apb_req = i_psel & i_penable & (state == IDLE);
   assign gnt_apb = ~i_rst & apb_req & (~i_mem_req | force_apb);
   assign o_mem_gnt = ~i_rst & i_mem_req & ~gnt_apb;
   assign o_sram_cen = ~(o_mem_gnt | gnt_apb);
   assign o_sram_gwen = o_mem_gnt ? ~i_mem_write : gnt_apb ? ~i_pwrite : 1'b1;
   assign o_sram_wen = o_mem_gnt ? ~i_mem_wmask : gnt_apb ? {32{~i_pwrite}} : '1;
   assign o_sram_a = o_mem_gnt ? i_mem_addr[ADDR_W-1:0] : gnt_apb ? i_paddr[ADDR_W+1:2] : '0;
   assign o_sram_d = o_mem_gnt ? i_mem_wdata : gnt_apb ? i_pwdata : '0;
   assign o_mem_rdata = i_sram_q;
   assign o_prdata = o_pready ? i_sram_q : '0;
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state <= IDLE;
         o_pready <= 1'b0;
         o_mem_rvalid <= 1'b0;
      end else begin
         state <= gnt_apb ? RESP : IDLE;
         o_pready <= gnt_apb;
         o_mem_rvalid <= o_mem_gnt & ~i_mem_write;
      end
`ifdef AIB_SRAM_ARB_STARVE_EN
   logic [7:0] wait_cnt;
   assign force_apb = wait_cnt == 8'(MAX_WAIT);
   always_ff @(posedge i_clk)
      if (i_rst || !apb_req || gnt_apb) wait_cnt <= '0;
      else if (!force_apb) wait_cnt <= wait_cnt + 8'd1;
`else
   logic unused_wait;
   assign unused_wait = ^8'(MAX_WAIT);
   assign force_apb = 1'b0;
`endif
endmodule

// File: tb/tb_aib_sram_arb.sv
// tb_aib_sram_arb: directed vectors with a queue scoreboard for APB and core read responses.
module tb_aib_sram_arb;
   logic clk = 1'b0, rst = 1'b1;
   logic mem_req = 0, mem_write = 0;
   logic [31:0] mem_addr = 0, mem_wdata = 0, mem_wmask = 0;
   logic mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic psel = 0, penable = 0, pwrite = 0;
   logic [31:0] paddr = 0, pwdata = 0;
   logic pready;
   logic [31:0] prdata;
   logic sram_cen, sram_gwen;
   logic [31:0] sram_wen, sram_d, sram_q;
   logic [11:0] sram_a;
   int checks = 0, errors = 0;
   string cn_q[$];
   logic [31:0] ca_q[$], ce_q[$], aexp_q[$], cexp_q[$];
   bit ard_q[$];
   logic [31:0] mem [0:4095];

   aib_sram_arb #(.ADDR_W(12), .MAX_WAIT(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_mem_req(mem_req), .i_mem_write(mem_write), .i_mem_addr(mem_addr),
      .i_mem_wdata(mem_wdata), .i_mem_wmask(mem_wmask),
      .o_mem_gnt(mem_gnt), .o_mem_rvalid(mem_rvalid), .o_mem_rdata(mem_rdata),
      .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite), .i_paddr(paddr),
      .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata),
      .o_sram_cen(sram_cen), .o_sram_gwen(sram_gwen), .o_sram_wen(sram_wen),
      .o_sram_a(sram_a), .o_sram_d(sram_d), .i_sram_q(sram_q)
   );

   always #5 clk = ~clk;

   // behavioural macro: bit-masked write, registered read
   always @(posedge clk)
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else sram_q <= mem[sram_a];
      end

   // monitor: the only process that steps the counters
   always @(negedge clk) begin : monitor
      string n;
      logic [31:0] a, e;
      bit rd;
      while (cn_q.size() > 0) begin
         n = cn_q.pop_front(); a = ca_q.pop_front(); e = ce_q.pop_front();
         checks++;
         if (a !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, a, e); end
      end
      if (pready === 1'b1) begin
         if (ard_q.size() == 0) begin
            checks++; errors++; $display("FAIL apb_unexpected_pready: got 1 expected 0");
         end else begin
            rd = ard_q.pop_front(); e = aexp_q.pop_front();
            if (rd) begin
               checks++;
               if (prdata !== e) begin errors++; $display("FAIL apb_prdata: got %h expected %h", prdata, e); end
            end
         end
      end
      if (mem_rvalid === 1'b1) begin
         checks++;
         if (cexp_q.size() == 0) begin
            errors++; $display("FAIL core_unexpected_rvalid: got 1 expected 0");
         end else begin
            e = cexp_q.pop_front();
            if (mem_rdata !== e) begin errors++; $display("FAIL core_rdata: got %h expected %h", mem_rdata, e); end
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      cn_q.push_back(n); ca_q.push_back(a); ce_q.push_back(e);
   endtask

   // setup phase then access phase; returns just after penable rises
   task automatic apb_start(input logic w, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk); psel = 1; penable = 0; pwrite = w; paddr = addr; pwdata = data;
      @(negedge clk); penable = 1; ard_q.push_back(!w); aexp_q.push_back(data);
   endtask

   task automatic apb_wait(input int exp_n, input bit keep);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (pready !== 1'b1 && n < 300);
      chk("apb_latency", n, exp_n);
      if (!keep) begin psel = 0; penable = 0; end
   endtask

   // drives a core request in the current cycle; for reads data is the expected word
   task automatic core(input logic w, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] mask);
      mem_req = 1; mem_write = w; mem_addr = addr; mem_wdata = data; mem_wmask = mask;
      #1;
      chk("core_gnt", mem_gnt, 1);
      chk("core_a", sram_a, addr[11:0]);
      chk("core_gwen", sram_gwen, !w);
      chk("core_wen", sram_wen, ~mask);
      if (!w) cexp_q.push_back(data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
`ifdef AIB_SRAM_ARB_STARVE_EN
      localparam int LIM = 10;
`else
      localparam int LIM = 100;
`endif
      bit eg, ep;
      repeat (2) @(negedge clk);
      mem_req = 1; #1;
      chk("rst_gnt", mem_gnt, 0);
      chk("rst_cen", sram_cen, 1);
      @(negedge clk); mem_req = 0; rst = 0; #1;
      chk("idle_cen", sram_cen, 1);
      chk("idle_pready", pready, 0);
      chk("idle_rvalid", mem_rvalid, 0);
      chk("idle_gnt", mem_gnt, 0);
      apb_start(1, 32'h40, 32'hDEADBEEF); #1;
      chk("apbw_a", sram_a, 12'h010);
      chk("apbw_gwen", sram_gwen, 0);
      chk("apbw_wen", sram_wen, 0);
      chk("apbw_d", sram_d, 32'hDEADBEEF);
      apb_wait(1, 0);
      apb_start(0, 32'hF0000041, 32'hDEADBEEF); #1;
      chk("apbr_a", sram_a, 12'h010);
      chk("apbr_gwen", sram_gwen, 1);
      apb_wait(1, 0);
      @(negedge clk); core(1, 5, 32'h0, 32'hFFFFFFFF);
      @(negedge clk); core(1, 5, 32'hFFFFFFFF, 32'h0000FFFF);
      @(negedge clk); core(0, 32'h00010005, 32'h0000FFFF, 0);
      @(negedge clk); mem_req = 0; #1;
      chk("rvalid_timing", mem_rvalid, 1);
      @(negedge clk); core(0, 5, 32'h0000FFFF, 0);
      @(negedge clk); core(0, 16, 32'hDEADBEEF, 0);
      @(negedge clk); mem_req = 0; #1;
      chk("b2b_rvalid", mem_rvalid, 1);
      // core read issued in the APB RESP cycle
      apb_start(0, 32'h40, 32'hDEADBEEF);
      apb_wait(1, 0);
      core(0, 5, 32'h0000FFFF, 0);
      chk("resp_cen", sram_cen, 0);
      @(negedge clk); mem_req = 0; #1;
      chk("resp_rvalid", mem_rvalid, 1);
      chk("resp_pready_drop", pready, 0);
      // reset in RESP with the access phase held
      apb_start(0, 32'h40, 32'hDEADBEEF);
      apb_wait(1, 1);
      rst = 1;
      @(negedge clk); rst = 0; ard_q.push_back(1); aexp_q.push_back(32'hDEADBEEF); #1;
      chk("rst_resp_pready", pready, 0);
      apb_wait(1, 0);
      // continuous core reads against an APB read
      @(negedge clk);
      mem_req = 1; mem_write = 0; mem_addr = 5; mem_wmask = 0;
      psel = 1; penable = 0; pwrite = 0; paddr = 32'h40; #1;
      chk("stv_setup_gnt", mem_gnt, 1);
      cexp_q.push_back(32'h0000FFFF);
      @(negedge clk); penable = 1; ard_q.push_back(1); aexp_q.push_back(32'hDEADBEEF);
      for (int k = 1; k <= LIM; k++) begin
         if (k > 1) @(negedge clk);
         #1;
`ifdef AIB_SRAM_ARB_STARVE_EN
         eg = (k != 9); ep = (k == 10);
`else
         eg = 1; ep = 0;
`endif
         chk("stv_gnt", mem_gnt, eg);
         chk("stv_pready", pready, ep);
         if (eg) cexp_q.push_back(32'h0000FFFF);
      end
`ifdef AIB_SRAM_ARB_STARVE_EN
      psel = 0; penable = 0;
      @(negedge clk); mem_req = 0;
`else
      @(negedge clk); mem_req = 0;
      apb_wait(1, 0);
`endif
      repeat (3) @(negedge clk);
      chk("apb_q_empty", ard_q.size(), 0);
      chk("core_q_empty", cexp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
